// File: rtl/mod60_countdown_timer.sv
// rtl/mod60_countdown_timer.sv - loadable mm:ss BCD countdown timer with one-second prescaler
//
// Purpose: mm:ss countdown held as four BCD digits, each field counting down
//   modulo 60. Start/pause/load controls, one-cycle done pulse on expiry.
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN (reload last loaded value
//   after expiry and keep running).
// Ports:
//   clk                              in  clock, rising edge
//   rst                              in  synchronous active-high reset
//   load, ld_min1/ld_min0/ld_sec1/ld_sec0  in  load request and BCD load value
//   start, pause                     in  run control requests
//   min1, min0, sec1, sec0           out current BCD value
//   running                          out high while in RUN
//   done                             out one-cycle expiry pulse
//   load_err                         out one-cycle pulse on rejected load
module mod60_countdown_timer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] ld_min1,
  input  logic [3:0] ld_min0,
  input  logic [3:0] ld_sec1,
  input  logic [3:0] ld_sec0,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   value_q, value_d;   // {min1, min0, sec1, sec0}
  logic          done_q, done_d;
  logic          load_err_q, load_err_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [15:0]   shadow_q, shadow_d;
`endif

  logic [15:0] ld_value;
  logic        ld_valid;
  logic        cur_zero;
  logic [15:0] dec_value;
  logic        dec_zero;

  assign ld_value = {ld_min1, ld_min0, ld_sec1, ld_sec0};
  assign ld_valid = (ld_min1 <= 4'd5) && (ld_min0 <= 4'd9) &&
                    (ld_sec1 <= 4'd5) && (ld_sec0 <= 4'd9);
  assign cur_zero = (value_q == 16'h0000);

  // Borrow chain: each digit that is already zero wraps to its field maximum
  // (9 for units, 5 for tens) and passes the borrow to the next digit up.
  always_comb begin
    dec_value = value_q;
    if (value_q[3:0] != 4'd0) begin
      dec_value[3:0] = value_q[3:0] - 4'd1;
    end else begin
      dec_value[3:0] = 4'd9;
      if (value_q[7:4] != 4'd0) begin
        dec_value[7:4] = value_q[7:4] - 4'd1;
      end else begin
        dec_value[7:4] = 4'd5;
        if (value_q[11:8] != 4'd0) begin
          dec_value[11:8] = value_q[11:8] - 4'd1;
        end else begin
          dec_value[11:8] = 4'd9;
          if (value_q[15:12] != 4'd0) begin
            dec_value[15:12] = value_q[15:12] - 4'd1;
          end else begin
            dec_value[15:12] = 4'd5;
          end
        end
      end
    end
  end

  assign dec_zero = (dec_value == 16'h0000);

  // Next-state logic; priority is load > pause > start > tick.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    value_d    = value_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    shadow_d   = shadow_q;
`endif
    if (load) begin
      if (ld_valid) begin
        value_d = ld_value;
        state_d = IDLE;
        presc_d = '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
        shadow_d = ld_value;
`endif
      end else begin
        load_err_d = 1'b1;
      end
    end else if (pause) begin
      // Pausing freezes the prescaler so a resume finishes the partial second.
      if (state_q == RUN) begin
        state_d = PAUSED;
      end
    end else if (start) begin
      if (state_q == IDLE && !cur_zero) begin
        state_d = RUN;
        presc_d = '0;
      end else if (state_q == PAUSED) begin
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
        // RUN at 00:00 only happens right after an auto-reload expiry.
        if (cur_zero) begin
          value_d = shadow_q;
        end else begin
          value_d = dec_value;
          if (dec_zero) begin
            done_d = 1'b1;
            if (shadow_q == 16'h0000) begin
              state_d = EXPIRED;
            end
          end
        end
`else
        value_d = dec_value;
        if (dec_zero) begin
          done_d  = 1'b1;
          state_d = EXPIRED;
        end
`endif
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      value_q    <= 16'h0000;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      shadow_q   <= 16'h0000;
`endif
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      value_q    <= value_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
      shadow_q   <= shadow_d;
`endif
    end
  end

  assign min1     = value_q[15:12];
  assign min0     = value_q[11:8];
  assign sec1     = value_q[7:4];
  assign sec0     = value_q[3:0];
  assign running  = (state_q == RUN);
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: doc/mod60_countdown_timer.md
# mod60_countdown_timer

Loadable mm:ss countdown timer. Each field is held as two BCD digits and counts down modulo 60, the inverse direction of the team's MOD60 up-counter. It is driven by an internal one-second prescaler with start, pause and load controls, and signals expiry with a one-cycle `done` pulse. It sits between the front-panel control logic and the seven-segment display driver, which consumes its four digit outputs directly.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per one-second tick; legal range ≥ 2. Prescaler width is `$clog2(TICK_DIV)`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: load request; samples `ld_min1`, `ld_min0`, `ld_sec1`, `ld_sec0`.
- `ld_min1`, `ld_min0`, `ld_sec1`, `ld_sec0` in 4 each: BCD load value; tens digits must be 0–5, units digits 0–9.
- `start` in 1: start or resume request.
- `pause` in 1: pause request.
- `min1`, `min0`, `sec1`, `sec0` out 4 each: current value, BCD.
- `running` out 1: high while in RUN.
- `done` out 1: one-cycle expiry pulse.
- `load_err` out 1: one-cycle pulse when a load is rejected.

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED. `running` = (state == RUN).
- Reset, when `rst`=1 at an edge:
  - state IDLE, all digits 0, prescaler 0.
  - `done`, `load_err` and `running` all 0.
  - Shadow register 00:00.
- Input priority per edge: `rst` > `load` > `pause` > `start` > tick.
- Load:
  - Valid (every digit in range, from any state): digits take the load value, state goes to IDLE, prescaler clears, shadow takes the value.
  - Invalid: rejected, `load_err`=1 for one cycle, all state unchanged.
- Pause:
  - In RUN: go to PAUSED; prescaler holds its value.
  - In any other state: ignored.
- Start:
  - IDLE with value ≠ 00:00: go to RUN, prescaler clears.
  - PAUSED: go to RUN, prescaler resumes from its held value.
  - Ignored in IDLE with value 00:00, in RUN, and in EXPIRED.
- Simultaneous `start` and `pause`: pause wins. IDLE stays IDLE; PAUSED stays PAUSED.
- Tick:
  - Asserted in RUN when prescaler == `TICK_DIV`-1; the prescaler then wraps to 0. Otherwise the prescaler increments in RUN only.
- Decrement on tick (borrow chain):
  - `sec0`>0: `sec0`-1.
  - Else `sec0`←9, then `sec1`>0: `sec1`-1.
  - Else `sec1`←5, then borrow into the minutes with the same rule (`min0` 9→…, `min1` 5→…).
  - Result is always valid BCD; digits never reach 10–15.
- Expiry:
  - The tick that produces 00:00 moves the state to EXPIRED.
  - `done`=1 in the same cycle the outputs first show 00:00, for exactly one cycle.
- EXPIRED holds 00:00 and is left only by `rst` or a valid load.

## Timing
- Outputs are registered; there is no combinational path from inputs to outputs.
- With `start` accepted at edge E0, the first decrement is visible after edge E0+`TICK_DIV`. Subsequent decrements follow every `TICK_DIV` cycles while in RUN.
- Load takes effect on the edge that samples it; `load_err` appears after that same edge.
- Reset mid-count: takes effect at the next edge regardless of state; no `done` is generated.
- Load in RUN: takes effect at once. State goes to IDLE, `running` drops the following cycle, and no tick is applied that cycle.

## Configuration
- `COUNTDOWN_AUTORELOAD_EN` defined:
  - At expiry, `done` pulses and the state stays RUN showing 00:00.
  - The next tick reloads the shadow value and counting continues.
  - If the shadow value is 00:00, the state goes to EXPIRED as normal.
- `COUNTDOWN_AUTORELOAD_EN` undefined:
  - The shadow register is not built.
  - Behaviour is exactly as described under Operation.

## Test plan
- Reset then basic count (`TICK_DIV`=4): load 00:03, start.
  - Outputs 00:02, 00:01, 00:00 at 4, 8 and 12 edges after start.
  - `done`=1 only on the 00:00 cycle; state EXPIRED.
- Borrow chain: load 10:00, start, one tick → 09:59. Load 01:00, one tick → 00:59.
- Pause/resume: load 00:05, start, pause after 2 cycles, hold 10 cycles, start.
  - No change while paused.
  - 00:04 appears 2 cycles after resume.
- Invalid load: load 00:6A while at 00:30 → `load_err` pulses once, value stays 00:30, state unchanged.
- Priority and edge cases:
  - `start`+`pause` together in IDLE at 00:05 → remains IDLE.
  - `start` at 00:00 → ignored.
  - `rst` mid-RUN at 03:17 → 00:00, IDLE, no `done`.
- Autoreload (macro defined): load 00:02, start.
  - 00:01, 00:00 with `done` pulse, then 00:02 one tick later with `running` still 1.
